// File: rtl/router_reg.sv
// router_reg -- datapath register stage on the router input side.
//
// Works beside the router control FSM and is driven by its one-hot state
// strobes. It captures the header byte, steers header/payload/parity bytes
// onto dout for the output FIFOs, parks one byte in hold_q across a
// FIFO-full stall, accumulates packet parity and reports the result.
//
// Ports:
//   clock          in   system clock, rising edge
//   resetn         in   asynchronous active-low reset
//   pkt_valid      in   high for header/payload bytes, low with the parity byte
//   data_in        in   packet byte; header[1:0] = address, header[7:2] = length
//   fifo_full      in   selected output FIFO is full
//   detect_add     in   FSM in DECODE_ADDRESS
//   lfd_state      in   FSM in LOAD_FIRST_DATA
//   ld_state       in   FSM in LOAD_DATA
//   full_state     in   FSM in FIFO_FULL_STATE
//   laf_state      in   FSM in LOAD_AFTER_FULL
//   rst_int_reg    in   FSM in CHECK_PARITY_ERROR
//   parity_done    out  parity byte of the current packet captured
//   low_pkt_valid  out  pkt_valid has fallen for the current packet
//   err            out  computed parity differs from received parity
//   dout           out  byte presented to the output FIFOs
module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  full_state,
  input  logic                  laf_state,
  input  logic                  rst_int_reg,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] header_q, header_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] int_par_q, int_par_d;
  logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
  logic                  par_done_q, par_done_d;
  logic                  low_pv_q, low_pv_d;
  logic                  err_q, err_d;

  logic hdr_cap;
  logic par_byte;

  // Address 3 is not a valid destination, so such a header is ignored.
  assign hdr_cap  = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
  assign par_byte = ld_state && !pkt_valid;

  always_comb begin
    dout_d     = dout_q;
    header_d   = header_q;
    hold_d     = hold_q;
    int_par_d  = int_par_q;
    pkt_par_d  = pkt_par_q;
    par_done_d = par_done_q;
    low_pv_d   = low_pv_q;
    err_d      = err_q;

    if (lfd_state)                  dout_d = header_q;
    else if (ld_state && !fifo_full) dout_d = data_in;
    else if (laf_state)              dout_d = hold_q;

    // A byte arriving while the FIFO is full is parked, not dropped; it is
    // replayed from hold_q in LOAD_AFTER_FULL.
    if (ld_state && fifo_full) hold_d = data_in;

    if (hdr_cap) begin
      header_d  = data_in;
      int_par_d = data_in;
    end else if (ld_state && pkt_valid) begin
      int_par_d = int_par_q ^ data_in;
    end

    if (par_byte) pkt_par_d = data_in;

    // hdr_cap needs pkt_valid high and par_byte needs it low: never both.
    if (hdr_cap)       par_done_d = 1'b0;
    else if (par_byte) par_done_d = 1'b1;

    if (par_byte)                    low_pv_d = 1'b1;
    else if (hdr_cap || rst_int_reg) low_pv_d = 1'b0;

    // The LOAD_AFTER_FULL path compares too, since after a stall on the
    // parity byte the FSM may leave without passing CHECK_PARITY_ERROR.
    if (hdr_cap)
      err_d = 1'b0;
    else if (rst_int_reg || (laf_state && par_done_q))
      err_d = (int_par_q != pkt_par_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout_q     <= '0;
      header_q   <= '0;
      hold_q     <= '0;
      int_par_q  <= '0;
      pkt_par_q  <= '0;
      par_done_q <= 1'b0;
      low_pv_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      header_q   <= header_d;
      hold_q     <= hold_d;
      int_par_q  <= int_par_d;
      pkt_par_q  <= pkt_par_d;
      par_done_q <= par_done_d;
      low_pv_q   <= low_pv_d;
      err_q      <= err_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = par_done_q;
  assign low_pkt_valid = low_pv_q;
  assign err           = err_q;

  // full_state needs no action: every register simply holds.
  logic unused_full;
  assign unused_full = full_state;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: walks the FSM strobe sequences of clean,
// bad-parity, stalled and reset-interrupted packets.
module tb_router_reg;

  localparam int DW = 8;
  // Strobe vector order: {detect_add, lfd, ld, full, laf, rst_int_reg}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_DA   = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_FULL = 6'b000100;
  localparam logic [5:0] S_LAF  = 6'b000010;
  localparam logic [5:0] S_RIR  = 6'b000001;

  logic          clock = 1'b0;
  logic          resetn;
  logic          pkt_valid;
  logic [DW-1:0] data_in;
  logic          fifo_full;
  logic          detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
  logic          parity_done, low_pkt_valid, err;
  logic [DW-1:0] dout;

  int checks = 0;
  int errors = 0;

  router_reg #(.DATA_WIDTH(DW)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .full_state(full_state), .laf_state(laf_state),
    .rst_int_reg(rst_int_reg), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err), .dout(dout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one FSM state for one clock, then sample 1 time unit after the edge.
  task automatic cyc(input logic [5:0] s, input logic pv, input logic ff, input logic [DW-1:0] din);
    {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg} = s;
    pkt_valid = pv;
    fifo_full = ff;
    data_in   = din;
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg} = S_NONE;
    pkt_valid = 1'b0; fifo_full = 1'b0; data_in = '0;
    #12;
    chk("rst_dout", dout, 8'h00);
    chk("rst_pdone", {7'b0, parity_done}, 8'h00);
    chk("rst_lpv", {7'b0, low_pkt_valid}, 8'h00);
    chk("rst_err", {7'b0, err}, 8'h00);
    resetn = 1'b1;
    @(negedge clock);

    // Clean packet: 0D 11 22 33 / parity 0D
    cyc(S_DA, 1, 0, 8'h0D);
    chk("p1_da_dout", dout, 8'h00);
    cyc(S_LFD, 1, 0, 8'h11);
    chk("p1_hdr", dout, 8'h0D);
    cyc(S_LD, 1, 0, 8'h11);  chk("p1_b1", dout, 8'h11);
    cyc(S_LD, 1, 0, 8'h22);  chk("p1_b2", dout, 8'h22);
    cyc(S_LD, 1, 0, 8'h33);
    chk("p1_b3", dout, 8'h33);
    chk("p1_pdone_pre", {7'b0, parity_done}, 8'h00);
    cyc(S_LD, 0, 0, 8'h0D);
    chk("p1_par", dout, 8'h0D);
    chk("p1_pdone", {7'b0, parity_done}, 8'h01);
    chk("p1_lpv", {7'b0, low_pkt_valid}, 8'h01);
    cyc(S_RIR, 0, 0, 8'h00);
    chk("p1_err", {7'b0, err}, 8'h00);
    chk("p1_lpv_clr", {7'b0, low_pkt_valid}, 8'h00);
    chk("p1_pdone_hold", {7'b0, parity_done}, 8'h01);

    // Bad parity: same packet, parity 0E
    cyc(S_DA, 1, 0, 8'h0D);
    cyc(S_LFD, 1, 0, 8'h11);
    cyc(S_LD, 1, 0, 8'h11);
    cyc(S_LD, 1, 0, 8'h22);
    cyc(S_LD, 1, 0, 8'h33);
    cyc(S_LD, 0, 0, 8'h0E);
    chk("p2_err_pre", {7'b0, err}, 8'h00);
    cyc(S_RIR, 0, 0, 8'h00);
    chk("p2_err", {7'b0, err}, 8'h01);
    cyc(S_NONE, 0, 0, 8'h00);
    chk("p2_err_sticky", {7'b0, err}, 8'h01);

    // Invalid address 3: nothing changes
    cyc(S_DA, 1, 0, 8'h07);
    chk("inv_err", {7'b0, err}, 8'h01);
    chk("inv_dout", dout, 8'h0E);
    chk("inv_pdone", {7'b0, parity_done}, 8'h01);
    cyc(S_LFD, 1, 0, 8'h00);
    chk("inv_hdr_kept", dout, 8'h0D);

    // New header 04 clears err; 1-byte packet 55, parity 04^55=51
    cyc(S_DA, 1, 0, 8'h04);
    chk("p3_err_clr", {7'b0, err}, 8'h00);
    chk("p3_pdone_clr", {7'b0, parity_done}, 8'h00);
    cyc(S_LFD, 1, 0, 8'h55); chk("p3_hdr", dout, 8'h04);
    cyc(S_LD, 1, 0, 8'h55);  chk("p3_b1", dout, 8'h55);
    cyc(S_LD, 0, 0, 8'h51);
    cyc(S_RIR, 0, 0, 8'h00);
    chk("p3_err", {7'b0, err}, 8'h00);

    // FIFO full mid-payload
    cyc(S_DA, 1, 0, 8'h0D);
    cyc(S_LFD, 1, 0, 8'h11);
    cyc(S_LD, 1, 0, 8'h11);
    cyc(S_LD, 1, 1, 8'h22);  chk("p4_stall", dout, 8'h11);
    cyc(S_FULL, 1, 1, 8'h33); chk("p4_full", dout, 8'h11);
    cyc(S_LAF, 1, 0, 8'h33); chk("p4_laf", dout, 8'h22);
    chk("p4_laf_err", {7'b0, err}, 8'h00);
    cyc(S_LD, 1, 0, 8'h33);  chk("p4_b3", dout, 8'h33);
    cyc(S_LD, 0, 0, 8'h0D);
    cyc(S_RIR, 0, 0, 8'h00);
    chk("p4_err", {7'b0, err}, 8'h00);

    // Full on the parity byte, good parity
    cyc(S_DA, 1, 0, 8'h0D);
    cyc(S_LFD, 1, 0, 8'h11);
    cyc(S_LD, 1, 0, 8'h11);
    cyc(S_LD, 1, 0, 8'h22);
    cyc(S_LD, 1, 0, 8'h33);
    cyc(S_LD, 0, 1, 8'h0D);
    chk("p5_dout_hold", dout, 8'h33);
    chk("p5_pdone", {7'b0, parity_done}, 8'h01);
    chk("p5_lpv", {7'b0, low_pkt_valid}, 8'h01);
    cyc(S_FULL, 0, 1, 8'h00);
    cyc(S_LAF, 0, 0, 8'h00);
    chk("p5_laf_dout", dout, 8'h0D);
    chk("p5_err", {7'b0, err}, 8'h00);

    // Full on the parity byte, bad parity 0E
    cyc(S_DA, 1, 0, 8'h0D);
    cyc(S_LFD, 1, 0, 8'h11);
    cyc(S_LD, 1, 0, 8'h11);
    cyc(S_LD, 1, 0, 8'h22);
    cyc(S_LD, 1, 0, 8'h33);
    cyc(S_LD, 0, 1, 8'h0E);
    cyc(S_FULL, 0, 1, 8'h00);
    chk("p6_err_pre", {7'b0, err}, 8'h00);
    cyc(S_LAF, 0, 0, 8'h00);
    chk("p6_laf_dout", dout, 8'h0E);
    chk("p6_err", {7'b0, err}, 8'h01);

    // Reset mid-packet, asynchronously between edges
    cyc(S_DA, 1, 0, 8'h0D);
    chk("p7_err_clr", {7'b0, err}, 8'h00);
    cyc(S_LFD, 1, 0, 8'h11);
    cyc(S_LD, 1, 0, 8'h11);
    cyc(S_LD, 1, 0, 8'h22);
    chk("p7_pre_rst", dout, 8'h22);
    {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg} = S_NONE;
    #2 resetn = 1'b0;
    #1;
    chk("arst_dout", dout, 8'h00);
    chk("arst_flags", {5'b0, parity_done, low_pkt_valid, err}, 8'h00);
    @(negedge clock);
    resetn = 1'b1;

    // Next packet 09 AA BB, parity 18
    cyc(S_DA, 1, 0, 8'h09);
    cyc(S_LFD, 1, 0, 8'hAA); chk("p8_hdr", dout, 8'h09);
    cyc(S_LD, 1, 0, 8'hAA);  chk("p8_b1", dout, 8'hAA);
    cyc(S_LD, 1, 0, 8'hBB);  chk("p8_b2", dout, 8'hBB);
    cyc(S_LD, 0, 0, 8'h18);
    chk("p8_par", dout, 8'h18);
    chk("p8_pdone", {7'b0, parity_done}, 8'h01);
    cyc(S_RIR, 0, 0, 8'h00);
    chk("p8_err", {7'b0, err}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
